// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and the error-result pattern for the
// multi-cycle ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SLT = 6'b101010;
    localparam logic [5:0] OP_MUL = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_HOLD
    } state_t;

    // Wide enough for any lenD; users slice the low lenD bits.
    localparam logic [63:0] ERR_RESULT = '1;

endpackage

// File: rtl/alu_multiciclo_if.sv
// Operand-side and result-side handshake bundle of the multi-cycle ALU.
interface alu_multiciclo_if #(
    parameter int lenD = 8,
    parameter int lenO = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [lenD-1:0] nr1;
    logic [lenD-1:0] nr2;
    logic [lenO-1:0] operacion;
    logic            out_valid;
    logic            out_ready;
    logic [lenD-1:0] resultado;
    logic            zero;
    logic            negative;
    logic            carry;
    logic            overflow;
    logic            err;

    modport slave (
        input  in_valid, nr1, nr2, operacion, out_ready,
        output in_ready, out_valid, resultado, zero, negative, carry, overflow, err
    );

    modport master (
        output in_valid, nr1, nr2, operacion, out_ready,
        input  in_ready, out_valid, resultado, zero, negative, carry, overflow, err
    );
endinterface

// File: rtl/alu_mult_iter.sv
// Iterative shift-add multiplier: lenD cycles after start, done pulses for one
// cycle with the low lenD bits of a*b on product.
module alu_mult_iter #(
    parameter int lenD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [lenD-1:0] a,
    input  logic [lenD-1:0] b,
    output logic            done,
    output logic [lenD-1:0] product
);
    localparam int CW = $clog2(lenD);
    localparam logic [CW-1:0] LAST = CW'(lenD - 1);

    logic [lenD-1:0] a_sh;
    logic [lenD-1:0] b_sh;
    logic [lenD-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh <= a;
                b_sh <= b;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                // Truncated two's-complement product equals the signed low half.
                if (b_sh[0])
                    acc <= acc + a_sh;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_multiciclo.sv
// Registered ALU with valid/ready on both sides, status flags and an
// iterative multiply that holds results under backpressure.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int lenD = 8,
    parameter int lenO = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_multiciclo_if.slave bus
);
    localparam int MSB = lenD - 1;
    localparam logic [lenD-1:0] LEN_D = lenD[lenD-1:0];

    state_t          state, state_nxt;
    logic            accept, is_mul, load_alu, start_mul, mul_done;
    logic [lenD-1:0] a, b, prod;
    logic [lenD-1:0] alu_res, diff;
    logic [lenD:0]   sum;
    logic            alu_c, alu_v, alu_e, shift_big;
    logic [lenD-1:0] res_q;
    logic            zero_q, neg_q, carry_q, ovf_q, err_q;

    assign a      = bus.nr1;
    assign b      = bus.nr2;
    assign is_mul = (bus.operacion == lenO'(OP_MUL));

    assign bus.in_ready  = rst_n && ((state == ST_IDLE) || ((state == ST_HOLD) && bus.out_ready));
    assign bus.out_valid = (state == ST_HOLD);
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_e     = 1'b0;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = a - b;
        shift_big = (b >= LEN_D);
        case (bus.operacion)
            lenO'(OP_ADD): begin
                alu_res = sum[lenD-1:0];
                alu_c   = sum[lenD];
                alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            lenO'(OP_SUB): begin
                alu_res = diff;
                alu_c   = (a < b);
                alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            lenO'(OP_AND): alu_res = a & b;
            lenO'(OP_OR):  alu_res = a | b;
            lenO'(OP_XOR): alu_res = a ^ b;
            lenO'(OP_NOR): alu_res = ~(a | b);
            lenO'(OP_SRA): alu_res = shift_big ? {lenD{a[MSB]}} : $unsigned($signed(a) >>> b);
            lenO'(OP_SRL): alu_res = shift_big ? '0 : (a >> b);
            lenO'(OP_SLT): alu_res[0] = ($signed(a) < $signed(b));
            lenO'(OP_MUL): alu_res = '0;
            default: begin
                alu_res = ERR_RESULT[lenD-1:0];
                alu_e   = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_alu  = 1'b0;
        start_mul = 1'b0;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        start_mul = 1'b1;
                        state_nxt = ST_MUL;
                    end else begin
                        load_alu  = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if ((state == ST_HOLD) && bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MUL: if (mul_done) state_nxt = ST_HOLD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_alu) begin
                res_q   <= alu_res;
                zero_q  <= (alu_res == '0);
                neg_q   <= alu_res[MSB];
                carry_q <= alu_c;
                ovf_q   <= alu_v;
                err_q   <= alu_e;
            end else if ((state == ST_MUL) && mul_done) begin
                res_q   <= prod;
                zero_q  <= (prod == '0);
                neg_q   <= prod[MSB];
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

    assign bus.resultado = res_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.err       = err_q;

    alu_mult_iter #(.lenD(lenD)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (prod)
    );

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, registered ALU with a valid/ready handshake on both sides, status flags and an iterative multiply. It sits between the operand-loading logic and the result/display stage. It replaces the purely combinational ALU wherever results must be held under backpressure or a multi-cycle operation is required.

## Interface
- lenD, 8: operand/result width in bits (≥4).
- lenO, 6: opcode width.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and opcode presented.
- in_ready  out  1  block accepts the operation this cycle.
- nr1  in  lenD  signed operand A.
- nr2  in  lenD  signed operand B (shift amount, unsigned, for shifts).
- operacion  in  lenO  opcode.
- out_valid  out  1  resultado/flags valid.
- out_ready  in  1  consumer takes result this cycle.
- resultado  out  lenD  result.
- zero, negative, carry, overflow  out  1 each  status flags.
- err  out  1  unsupported opcode.

## Operation
- Opcodes:
  - ADD 100000: A+B.
  - SUB 100010: A−B.
  - AND 100100.
  - OR 100101.
  - XOR 100110.
  - NOR 100111.
  - SRA 000011: arithmetic right shift, sign-filled.
  - SRL 000010: logical right shift, zero-filled.
  - SLT 101010: 1 if A<B signed, else 0.
  - MUL 011000: low lenD bits of A·B.
- Shifts: amount = nr2 as unsigned. If amount ≥ lenD, SRL gives 0 and SRA gives all sign bits.
- Flags:
  - zero = (resultado==0).
  - negative = resultado[lenD-1].
  - carry: ADD = unsigned carry-out; SUB = borrow (A<B unsigned); all other ops = 0.
  - overflow: ADD/SUB = signed overflow; all other ops = 0.
- Unsupported opcode: resultado = all ones, err=1, zero=0, negative=1, carry=0, overflow=0. Otherwise err=0.
- Outputs are registered and change only when a new result is loaded.
- FSM states:
  - IDLE: no result held. in_ready=1, out_valid=0.
  - MUL: iterative shift-add multiply running. in_ready=0, out_valid=0. Counter runs 0..lenD−1.
  - HOLD: result held. out_valid=1, in_ready=out_ready.
- Transitions:
  - IDLE, accept non-MUL → HOLD with result loaded.
  - IDLE, accept MUL → MUL with operands latched and counter cleared.
  - MUL, counter==lenD−1 → HOLD with product loaded.
  - HOLD, out_ready and in_valid: result consumed and the new op accepted in the same cycle. Non-MUL → HOLD with new result; MUL → MUL.
  - HOLD, out_ready and not in_valid → IDLE.
  - HOLD, not out_ready → stay HOLD. resultado and flags are stable.
- Accept condition: in_valid && in_ready. nr1, nr2 and operacion are sampled only on the accept edge; input changes at other times are ignored.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state IDLE; out_valid=0; resultado=0; all flags and err=0; multiply counter and accumulator cleared.
  - in_ready=0 while rst_n=0.
  - Reset mid-MUL or mid-HOLD aborts the operation; the held result is lost.
- Non-MUL latency: out_valid rises 1 cycle after accept.
- MUL latency: out_valid rises lenD+1 cycles after accept. in_ready=0 for those cycles.
- Throughput: 1 op/cycle for non-MUL ops when out_ready is held high.
- in_ready is combinational from state and out_ready. No combinational path from in_valid to out_valid.
- out_valid, once high, stays high with stable outputs until the cycle out_ready=1.

## Structure
- Package alu_pkg:
  - opcode localparams (ADD…MUL);
  - FSM state encoding (IDLE, MUL, HOLD);
  - the error-result constant.
- Sub-module alu_mult_iter:
  - ports: start, operands, done, product;
  - lenD-cycle shift-add, low lenD bits only;
  - instantiated once.
- Single-cycle ops: one combinational case in the top module, registered into resultado and flags.

## Test plan
- ADD 0x7F+0x01, out_ready=1 → next cycle resultado=0x80, overflow=1, negative=1, carry=0, zero=0.
- SUB 0x00−0x01 → 0xFF, carry=1, overflow=0; then SUB 0x05−0x05 → 0x00, zero=1.
- SRA 0x80 by 2 → 0xE0; SRL 0x80 by 2 → 0x20; SRA 0x80 by 9 → 0xFF; SRL 0x80 by 9 → 0x00.
- MUL −3·5 (0xFD, 0x05):
  - in_ready=0 for 9 cycles;
  - out_valid rises exactly 9 cycles after accept with resultado=0xF1, negative=1;
  - assert rst_n=0 mid-MUL on a second run → IDLE, out_valid=0, no result emitted.
- Backpressure:
  - ADD result held with out_ready=0 for 5 cycles → resultado stable, in_ready=0;
  - raise out_ready together with in_valid (XOR 0x0F^0xFF) → old result consumed, 0xF0 valid next cycle.
- Opcode 111111 → resultado=0xFF, err=1; following valid AND 0xF0&0x3C → 0x30, err=0.
